// File: rtl/memory_stage_if.sv
// Request/response bundle between the execute side and the memory stage.
// The master drives the request fields; the slave (memory_stage) returns
// busy, done, valM and dmem_error.
interface memory_stage_if;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic        busy;
  logic        done;
  logic [63:0] valM;
  logic        dmem_error;

  modport master (
    output start, icode, valE, valA, valP,
    input  busy, done, valM, dmem_error
  );

  modport slave (
    input  start, icode, valE, valA, valP,
    output busy, done, valM, dmem_error
  );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 data-memory stage: byte-serial load/store against an internal
// byte-addressed memory, eight bytes per access, little-endian.
// Optional macro ALIGN_CHECK_EN: when defined, a memory op whose address is
// not 8-byte aligned faults instead of being performed.
module memory_stage #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic           clk,
  input  logic           rst,
  memory_stage_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Highest legal start address: the full 8-byte word must fit in memory.
  localparam logic [63:0] MAX_ADDR = 64'(DEPTH - 8);

  state_t        state;
  logic [2:0]    cnt;
  logic [AW-1:0] addr_r;
  logic [63:0]   wdata;
  logic          is_load;
  logic          is_store;
  logic [63:0]   shreg;
  logic [AW-1:0] ptr;

  logic [7:0]    mem [DEPTH];

  logic          op_load;
  logic          op_store;
  logic [63:0]   req_addr;
  logic [63:0]   req_data;
  logic          fault;

  // Decode the requested operation, its address/data source and any fault.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    op_load  = 1'b0;
    op_store = 1'b0;
    req_addr = bus.valE;
    req_data = bus.valA;
    case (bus.icode)
      4'h4: op_store = 1'b1;                           // rmmovq
      4'h5: op_load  = 1'b1;                           // mrmovq
      4'h8: begin op_store = 1'b1; req_data = bus.valP; end // call
      4'h9: begin op_load  = 1'b1; req_addr = bus.valA; end // ret
      4'hA: op_store = 1'b1;                           // pushq
      4'hB: begin op_load  = 1'b1; req_addr = bus.valA; end // popq
      default: ;
    endcase
`ifdef ALIGN_CHECK_EN
    fault = (op_load || op_store) &&
            ((req_addr > MAX_ADDR) || (req_addr[2:0] != 3'd0));
`else
    fault = (op_load || op_store) && (req_addr > MAX_ADDR);
`endif
  end

  // Byte address of the current transfer.
  assign ptr = addr_r + AW'(cnt);

  // Control FSM with registered outputs; loads assemble through shreg.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) begin
      state          <= IDLE;
      cnt            <= 3'd0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.valM       <= 64'd0;
      bus.dmem_error <= 1'b0;
      is_load        <= 1'b0;
      is_store       <= 1'b0;
      addr_r         <= '0;
      wdata          <= 64'd0;
      shreg          <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.busy <= 1'b1;
            if ((op_load || op_store) && !fault) begin
              state    <= ACCESS;
              cnt      <= 3'd0;
              addr_r   <= req_addr[AW-1:0];
              wdata    <= req_data;
              is_load  <= op_load;
              is_store <= op_store;
            end else begin
              state          <= DONE;
              bus.done       <= 1'b1;
              bus.valM       <= 64'd0;
              bus.dmem_error <= fault;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 3'd1;
          if (is_load) shreg <= {mem[ptr], shreg[63:8]};
          if (cnt == 3'd7) begin
            state          <= DONE;
            bus.done       <= 1'b1;
            bus.dmem_error <= 1'b0;
            bus.valM       <= is_load ? {mem[ptr], shreg[63:8]} : 64'd0;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store path: one byte per ACCESS cycle; reset suppresses the write.
  always_ff @(posedge clk) begin
    // NOTE: memory contents are deliberately not reset; only control state is.
    if (!rst && state == ACCESS && is_store)
      mem[ptr] <= wdata[cnt*8 +: 8];
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus pushes expected responses,
// a monitor pops and compares on every done pulse (value, error, latency).
module tb_memory_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [63:0] valm;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  memory_stage_if bus();

  memory_stage #(.DEPTH(1024), .AW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("valM", bus.valM, e.valm);
        check("dmem_error", {63'd0, bus.dmem_error}, {63'd0, e.err});
        check("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("idle_timeout", {63'd0, bus.busy}, 64'd0);
  endtask

  task automatic drive(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p);
    bus.icode = ic;
    bus.valE  = e;
    bus.valA  = a;
    bus.valP  = p;
    bus.start = 1'b1;
  endtask

  task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, input logic [63:0] exp_m, input logic exp_err,
                       input int lat);
    @(negedge clk);
    drive(ic, e, a, p);
    exp_q.push_back('{exp_m, exp_err, cyc + lat});
    @(negedge clk);
    bus.start = 1'b0;
    bus.valE  = 64'hBAD0_BAD0_BAD0_BAD0;
    bus.valA  = 64'hBAD1_BAD1_BAD1_BAD1;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.icode = 4'h0;
    bus.valE  = 64'd0;
    bus.valA  = 64'd0;
    bus.valP  = 64'd0;
    repeat (3) @(negedge clk);
    // Reset and start together: reset must win.
    bus.icode = 4'h2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_valM", bus.valM, 64'd0);
    check("rst_err", {63'd0, bus.dmem_error}, 64'd0);

    // Write then read.
    issue(4'h4, 64'h10, 64'h0123456789ABCDEF, 64'd0, 64'd0, 1'b0, 9);
    issue(4'h5, 64'h10, 64'd0, 64'd0, 64'h0123456789ABCDEF, 1'b0, 9);
    check("byte_0x10", {56'd0, dut.mem[16]}, 64'hEF);
    check("byte_0x17", {56'd0, dut.mem[23]}, 64'h01);
    issue(4'h4, 64'h18, 64'h8877665544332211, 64'd0, 64'd0, 1'b0, 9);

    // Stack pair at the last legal address.
    issue(4'hA, 64'h3F8, 64'hDEADBEEF00000001, 64'd0, 64'd0, 1'b0, 9);
    issue(4'hB, 64'h5555, 64'h3F8, 64'd0, 64'hDEADBEEF00000001, 1'b0, 9);

    // call stores valP; ret reads from valA.
    issue(4'h8, 64'h30, 64'hFFFF, 64'h0000000000401234, 64'd0, 1'b0, 9);
    issue(4'h9, 64'h7777, 64'h30, 64'd0, 64'h0000000000401234, 1'b0, 9);

    // Faults: one past the limit, and a huge address aliasing 0x3F8 in low bits.
    issue(4'h5, 64'h3F9, 64'd0, 64'd0, 64'd0, 1'b1, 1);
    issue(4'h4, 64'hFFFFFFFFFFFFFFF8, 64'hAAAAAAAAAAAAAAAA, 64'd0, 64'd0, 1'b1, 1);
    issue(4'h5, 64'h3F8, 64'd0, 64'd0, 64'hDEADBEEF00000001, 1'b0, 9);

    // No-op.
    issue(4'h2, 64'h10, 64'h10, 64'd0, 64'd0, 1'b0, 1);

    // Starts while busy are ignored; inputs change after capture.
    @(negedge clk);
    drive(4'h5, 64'h18, 64'd0, 64'd0);
    exp_q.push_back('{64'h8877665544332211, 1'b0, cyc + 9});
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      drive(4'h4, 64'h3F9, 64'h1234, 64'd0);
    end
    bus.start = 1'b0;
    check("ignore_idle", {63'd0, bus.busy}, 64'd0);

    // Reset mid-access: prior contents 0, four bytes land before reset.
    issue(4'h4, 64'h20, 64'd0, 64'd0, 64'd0, 1'b0, 9);
    @(negedge clk);
    drive(4'h4, 64'h20, 64'h1111111111111111, 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    issue(4'h5, 64'h20, 64'd0, 64'd0, 64'h0000000011111111, 1'b0, 9);

    // Unaligned read spanning the two words written earlier.
`ifdef ALIGN_CHECK_EN
    issue(4'h5, 64'h12, 64'd0, 64'd0, 64'd0, 1'b1, 1);
`else
    issue(4'h5, 64'h12, 64'd0, 64'd0, 64'h22110123456789AB, 1'b0, 9);
`endif

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Data-memory stage of the sequential Y86-64 processor. It sits between execute and writeback.
- Performs the load or store implied by icode against an internal byte-addressed data memory, one byte per clock.
- Returns valM to writeback, plus a done pulse and an error flag.
- The writeback stage samples valM on done.

Parameters:
DEPTH, 1024, data memory size in bytes; valid addresses are 0..DEPTH-1
AW, 10, internal address width; must satisfy 2**AW >= DEPTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request; sampled only in IDLE
icode  input  4  instruction code of the current instruction
valE  input  64  ALU result from execute
valA  input  64  register operand A from decode
valP  input  64  incremented PC from fetch
busy  output  1  high while an access is in progress (states ACCESS, DONE)
done  output  1  one-cycle pulse; valM and dmem_error are valid in this cycle
valM  output  64  data read from memory
dmem_error  output  1  address fault on the last request

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, valM=0, dmem_error=0, byte counter=0. Memory contents are not reset.
- Operation select, latched on start in IDLE:
  - rmmovq (4): write valA to M[valE].
  - mrmovq (5): read from M[valE].
  - call (8): write valP to M[valE].
  - ret (9): read from M[valA].
  - pushq (A): write valA to M[valE].
  - popq (B): read from M[valA].
  - Any other icode: no access.
- Inputs are captured into internal registers at start. They may change freely afterwards.
- Address check at start: fault if addr > DEPTH-8, compared at full 64-bit width with no wrap.
- States:
  - IDLE: on start with a memory op and no fault -> ACCESS, counter=0. On start with no-op or fault -> DONE.
  - ACCESS: one byte per clock. Byte i is at addr+i, little-endian, so byte i = data[8i+7:8i]. Stores write on the clock edge. Loads assemble into an internal shift register. After byte 7 -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- Values in DONE:
  - valM = assembled word for loads; 0 for stores, no-ops and faults.
  - dmem_error = 1 on fault, else 0.
  - A faulting store modifies no memory byte.
- Holding: valM and dmem_error hold their values until the next DONE.
- Latency, counted from the start edge to the cycle done is high:
  - 9 clocks for a valid memory op (8 ACCESS + 1).
  - 1 clock for a no-op or fault.
- start while busy=1 is ignored; no queuing.
- start and rst asserted together: rst wins.
- rst during ACCESS aborts to IDLE with no done pulse. Bytes already stored remain; the rest are untouched.
- Back-to-back: start may be asserted in the cycle after done. The cycle in which done is high is still busy, so start there is ignored.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- Defined: a memory op whose addr[2:0] != 0 also faults (dmem_error=1, no access, 1-clock latency).
- Undefined: unaligned accesses are legal. Each byte goes to addr+i; only the range check applies.

Test Plan:
- Write then read:
  - Stimulus: rmmovq, valE=0x10, valA=0x0123456789ABCDEF; then mrmovq, valE=0x10.
  - Response: the first done comes 9 clocks after start with valM=0. The second gives valM=0x0123456789ABCDEF. Byte 0x10 must read 0xEF, byte 0x17 must read 0x01.
- Stack pair:
  - Stimulus: pushq, valE=0x3F8, valA=0xDEADBEEF00000001; then popq, valA=0x3F8.
  - Response: popq returns valM=0xDEADBEEF00000001 with dmem_error=0.
- Fault:
  - Stimulus: mrmovq, valE=0x3F9 (DEPTH=1024); then rmmovq, valE=0xFFFFFFFFFFFFFFF8.
  - Response: each gives done after 1 clock, dmem_error=1, valM=0, and no memory change. Then mrmovq at 0x3F8 succeeds and clears dmem_error.
- No-op and ignore:
  - Stimulus: icode=2 (cmovxx) start; then start pulses while a mrmovq is busy.
  - Response: the cmovxx start gives done after 1 clock with valM=0. The extra starts produce no additional done; exactly one done per accepted request.
- Reset mid-access:
  - Stimulus: rmmovq to 0x20 with valA=0x1111111111111111 over prior contents 0; assert rst 4 clocks after start.
  - Response: no done; busy=0 on the next cycle. A later read at 0x20 returns 0x0000000011111111 (bytes 0..3 written: start edge plus 4 edges means byte transfers at edges 1..4, counter values 0..3).
- ALIGN_CHECK_EN:
  - Stimulus: mrmovq, valE=0x12, once with the macro defined and once without.
  - Response: with the macro, dmem_error=1 after 1 clock. Without it, a normal 9-clock read with dmem_error=0.
